// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes, FSM states and decode helpers shared by the sequential ALU
package seq_alu_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SLT    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_LUI    = 4'b1001;
    localparam logic [3:0] ALU_PASS_A = 4'b1010;
    localparam logic [3:0] ALU_PASS_B = 4'b1011;
    localparam logic [3:0] ALU_MULTU  = 4'b1100;
    localparam logic [3:0] ALU_DIVU   = 4'b1101;
    localparam logic [3:0] ALU_MFHI   = 4'b1110;
    localparam logic [3:0] ALU_MFLO   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// seq_alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
module seq_alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_div,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);

    logic [WIDTH-1:0] r_acc, r_q, r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic [WIDTH:0]   w_sum, w_shl, w_diff;

    assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_shl  = {r_acc, r_q[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, r_b};
    assign o_hi   = r_acc;
    assign o_lo   = r_q;
    assign o_last = (r_cnt == '0);

    // divide-by-zero preloads the architected answer so the commit path is uniform
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_q   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_start) begin
            r_div <= i_div;
            r_b   <= i_b;
            r_cnt <= CNT_W'(WIDTH - 1);
            r_acc <= (i_div && i_b == '0) ? i_a : '0;
            r_q   <= (i_div && i_b == '0) ? '1 : i_a;
        end else if (i_run) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_div) begin
                r_acc <= w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
                {r_acc, r_q} <= {w_sum, r_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked EX-stage ALU with iterative MULTU/DIVU and HI/LO
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ct,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_res,
    output logic             alu_zero,
    output logic             alu_ovf,
    output logic             alu_err
);

    localparam int MSB = WIDTH - 1;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_res, r_hi, r_lo, w_res, w_add, w_sub, w_hi, w_lo;
    logic             r_zero, r_ovf, r_err, r_out_valid, r_dz;
    logic             w_ovf, w_err, w_accept, w_iter, w_last;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign alu_res   = r_res;
    assign alu_zero  = r_zero;
    assign alu_ovf   = r_ovf;
    assign alu_err   = r_err;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_iter    = is_iter(alu_ct);
    assign w_add     = alu_src1 + alu_src2;
    assign w_sub     = alu_src1 - alu_src2;

    seq_alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_accept && w_iter),
        .i_div  (alu_ct == ALU_DIVU),
        .i_run  (r_state == S_MUL || r_state == S_DIV),
        .i_a    (alu_src1),
        .i_b    (alu_src2),
        .o_hi   (w_hi),
        .o_lo   (w_lo),
        .o_last (w_last)
    );

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (alu_ct)
            ALU_ADD: begin
                w_res = w_add;
                w_ovf = (alu_src1[MSB] == alu_src2[MSB]) && (w_add[MSB] != alu_src1[MSB]);
            end
            ALU_SUB: begin
                w_res = w_sub;
                w_ovf = (alu_src1[MSB] != alu_src2[MSB]) && (w_sub[MSB] != alu_src1[MSB]);
            end
            ALU_OR:             w_res = alu_src1 | alu_src2;
            ALU_AND:            w_res = alu_src1 & alu_src2;
            ALU_SLT:            w_res = {{(WIDTH-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
            ALU_LUI:            w_res = {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_PASS_A:         w_res = alu_src1;
            ALU_PASS_B:         w_res = alu_src2;
            ALU_MFHI:           w_res = r_hi;
            ALU_MFLO:           w_res = r_lo;
            ALU_MULTU, ALU_DIVU: ;
            default:            w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (w_accept && w_iter)
                    w_next = (alu_ct == ALU_MULTU) ? S_MUL : (alu_src2 == '0) ? S_DONE : S_DIV;
            S_MUL, S_DIV:
                if (w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // DONE is the only place HI/LO change, so a flush before or in it leaves them intact
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_res       <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_dz        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= 1'b0;
            if (w_accept && !w_iter) begin
                r_res       <= w_res;
                r_zero      <= (w_res == '0);
                r_ovf       <= w_ovf;
                r_err       <= w_err;
                r_out_valid <= 1'b1;
            end
            if (w_accept && w_iter)
                r_dz <= (alu_ct == ALU_DIVU) && (alu_src2 == '0);
            if (r_state == S_DONE && !flush) begin
                r_hi        <= w_hi;
                r_lo        <= w_lo;
                r_res       <= w_lo;
                r_zero      <= (w_lo == '0);
                r_ovf       <= 1'b0;
                r_err       <= r_dz;
                r_out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;

    localparam int W = 32;
    localparam logic [3:0] OP_AND = 4'b0000, OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
    localparam logic [3:0] OP_OR = 4'b1000, OP_LUI = 4'b1001, OP_PA = 4'b1010, OP_PB = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100, OP_DIVU = 4'b1101, OP_MFHI = 4'b1110, OP_MFLO = 4'b1111;

    logic         clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic         in_ready, out_valid, alu_zero, alu_ovf, alu_err;
    logic [3:0]   alu_ct = 4'b0;
    logic [W-1:0] alu_src1 = '0, alu_src2 = '0, alu_res;
    int           errors = 0, checks = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ct(alu_ct), .alu_src1(alu_src1), .alu_src2(alu_src2), .out_valid(out_valid),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_err(alu_err)
    );

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_ct   = op;
        alu_src1 = a;
        alu_src2 = b;
    endtask

    // called right after drive() at a negedge; reports cycle index of out_valid
    task automatic wait_done(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (!in_ready) busy++;
            if (out_valid) lat = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if ({in_ready, out_valid, alu_zero, alu_ovf, alu_err} !== 5'b10100) begin errors++; $display("FAIL reset_flags got=%b exp=10100", {in_ready, out_valid, alu_zero, alu_ovf, alu_err}); end
        checks++; if (alu_res !== '0) begin errors++; $display("FAIL reset_res got=%h exp=0", alu_res); end
    endtask

    task automatic test_add();
        @(negedge clk);
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, alu_ovf, alu_zero, alu_err} !== 4'b1100) begin errors++; $display("FAIL add_flags got=%b exp=1100", {out_valid, alu_ovf, alu_zero, alu_err}); end
        checks++; if (alu_res !== 32'h8000_0000) begin errors++; $display("FAIL add_res got=%h exp=80000000", alu_res); end
        @(negedge clk);
        checks++; if ({out_valid, alu_res} !== {1'b0, 32'h8000_0000}) begin errors++; $display("FAIL add_hold got=%b/%h exp=0/80000000", out_valid, alu_res); end
    endtask

    task automatic test_logic();
        logic [3:0]   ops [7] = '{OP_SUB, OP_OR, OP_AND, OP_PA, OP_PB, OP_ADD, OP_SLT};
        logic [W-1:0] as  [7] = '{32'h8000_0000, 32'h0000_00F0, 32'h0000_F0F0, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] bs  [7] = '{32'h1, 32'h0000_0F00, 32'h0000_FF00, 32'h0, 32'h1234_5678, 32'h1, 32'h7FFF_FFFF};
        logic [W-1:0] ex  [7] = '{32'h7FFF_FFFF, 32'h0000_0FF0, 32'h0000_F000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h1};
        logic         eo  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], as[i], bs[i]);
            @(negedge clk);
            checks++; if ({out_valid, alu_res, alu_ovf, alu_zero} !== {1'b1, ex[i], eo[i], ex[i] == '0}) begin errors++; $display("FAIL logic_%0d got=%b/%h/%b/%b exp res=%h ovf=%b", i, out_valid, alu_res, alu_ovf, alu_zero, ex[i], eo[i]); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(OP_SUB, 32'd5, 32'd5);
        @(negedge clk);
        checks++; if ({out_valid, alu_res, alu_zero} !== {1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL b2b_sub got=%b/%h/%b exp=1/0/1", out_valid, alu_res, alu_zero); end
        drive(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        @(negedge clk);
        checks++; if ({out_valid, alu_res, alu_zero} !== {1'b1, 32'h1, 1'b0}) begin errors++; $display("FAIL b2b_slt got=%b/%h/%b exp=1/1/0", out_valid, alu_res, alu_zero); end
        drive(OP_LUI, 32'hFFFF_FFFF, 32'h0000_1234);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'h1234_0000}) begin errors++; $display("FAIL b2b_lui got=%b/%h exp=1/12340000", out_valid, alu_res); end
    endtask

    task automatic test_multu();
        int lat, busy;
        drive(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_done(lat, busy);
        checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got=%0d exp=34", lat); end
        checks++; if (busy !== 33) begin errors++; $display("FAIL mul_busy got=%0d exp=33", busy); end
        checks++; if ({alu_res, alu_ovf, alu_err} !== {32'hFFFF_FFFE, 2'b00}) begin errors++; $display("FAIL mul_res got=%h/%b/%b exp=fffffffe/0/0", alu_res, alu_ovf, alu_err); end
        drive(OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'h1}) begin errors++; $display("FAIL mul_mfhi got=%b/%h exp=1/1", out_valid, alu_res); end
        drive(OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'hFFFF_FFFE}) begin errors++; $display("FAIL mul_mflo got=%b/%h exp=1/fffffffe", out_valid, alu_res); end
    endtask

    task automatic test_divu();
        int lat, busy;
        drive(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, busy);
        checks++; if ({lat, alu_res, alu_err} !== {34, 32'd14, 1'b0}) begin errors++; $display("FAIL div_lo got lat=%0d res=%h err=%b exp 34/e/0", lat, alu_res, alu_err); end
        drive(OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (alu_res !== 32'd2) begin errors++; $display("FAIL div_hi got=%h exp=2", alu_res); end
        drive(OP_DIVU, 32'd9, 32'd0);
        wait_done(lat, busy);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dz_latency got=%0d exp=2", lat); end
        checks++; if ({alu_res, alu_err, alu_ovf} !== {32'hFFFF_FFFF, 2'b10}) begin errors++; $display("FAIL dz_res got=%h/%b/%b exp=ffffffff/1/0", alu_res, alu_err, alu_ovf); end
        drive(OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({alu_res, alu_err} !== {32'd9, 1'b0}) begin errors++; $display("FAIL dz_hi got=%h/%b exp=9/0", alu_res, alu_err); end
    endtask

    task automatic test_flush();
        int lat, busy, seen;
        drive(OP_DIVU, 32'd5, 32'd2);
        wait_done(lat, busy);
        seen = 0;
        drive(OP_MULTU, 32'd3, 32'd4);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) seen++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_pulse got=%0d exp=0", seen); end
        drive(OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'd2}) begin errors++; $display("FAIL flush_mflo got=%b/%h exp=1/2", out_valid, alu_res); end
        drive(OP_ADD, 32'd1, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if ({out_valid, alu_res} !== {1'b0, 32'd2}) begin errors++; $display("FAIL flush_idle got=%b/%h exp=0/2", out_valid, alu_res); end
    endtask

    task automatic test_unknown();
        drive(4'b0011, 32'h55, 32'hAA);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, alu_res, alu_err, alu_zero} !== {1'b1, 32'h0, 2'b11}) begin errors++; $display("FAIL unknown got=%b/%h/%b/%b exp=1/0/1/1", out_valid, alu_res, alu_err, alu_zero); end
    endtask

    task automatic test_rst_mid();
        int seen;
        seen = 0;
        drive(OP_DIVU, 32'd100, 32'd7);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({in_ready, out_valid, alu_zero, alu_ovf, alu_err, alu_res} !== {5'b10100, 32'h0}) begin errors++; $display("FAIL rst_mid got=%b res=%h exp=10100 res=0", {in_ready, out_valid, alu_zero, alu_ovf, alu_err}, alu_res); end
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_pulse got=%0d exp=0", seen); end
        drive(OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rst_hi got=%b/%h exp=1/0", out_valid, alu_res); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_back_to_back();
        test_multu();
        test_divu();
        test_flush();
        test_unknown();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
